// File: rtl/main_memory_if.sv
// Cache-to-memory block bus: the cache drives the access, memory returns the addressed block.
// No handshake. Every access completes in the cycle it is presented.
interface main_memory_if #(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 4
);
    logic                          read_write;
    logic [ADDR_W-1:0]             address;
    logic [WORD_W*BLK_WORDS-1:0]   write_data;
    logic [WORD_W*BLK_WORDS-1:0]   read_data;

    modport master (
        output read_write,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  read_write,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/main_memory.sv
// Block-wide backing store: combinational read (0 cycles), whole-block write at the clock edge.
// No backpressure: always ready. Reset reloads the word-index pattern asynchronously.
module main_memory #(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    main_memory_if.slave   bus
);
    localparam int BLK_W   = WORD_W * BLK_WORDS;
    localparam int OFF_W   = $clog2(BLK_WORDS * (WORD_W / 8));
    localparam int IDX_W   = ADDR_W - OFF_W;
    localparam int NUM_BLK = 2 ** IDX_W;

    logic [BLK_W-1:0] mem_q [NUM_BLK];
    logic [IDX_W-1:0] blk_idx;
    logic             unused_offset;

    assign blk_idx       = bus.address[ADDR_W-1:OFF_W];
    assign unused_offset = ^bus.address[OFF_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Word w of the flat space resets to the value w.
            for (int b = 0; b < NUM_BLK; b++) begin
                for (int k = 0; k < BLK_WORDS; k++) begin
                    mem_q[b][k*WORD_W +: WORD_W] <= WORD_W'(b * BLK_WORDS + k);
                end
            end
        end else if (bus.read_write) begin
            mem_q[blk_idx] <= bus.write_data;
        end
    end

    assign bus.read_data = mem_q[blk_idx];
endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    main_memory_if bus ();
    main_memory dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference: flat array of 256 words, block b word k = word 4b+k.
    logic [31:0] model [256];

    typedef struct {
        logic [127:0] exp;
        string        name;
    } exp_t;
    exp_t exp_q[$];

    logic mon_req = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    function automatic logic [127:0] blk_of(logic [9:0] a);
        int b;
        b = int'(a[9:4]);
        return {model[4*b+3], model[4*b+2], model[4*b+1], model[4*b]};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 256; w++) model[w] = 32'(w);
    endtask

    task automatic model_write(logic [9:0] a, logic [127:0] d);
        int b;
        b = int'(a[9:4]);
        for (int k = 0; k < 4; k++) model[4*b+k] = d[32*k +: 32];
    endtask

    task automatic check(string nm, logic [9:0] a);
        exp_t e;
        e.exp  = blk_of(a);
        e.name = nm;
        exp_q.push_back(e);
        mon_req = 1'b1;
        #1;
        mon_req = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge mon_req);
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor_underflow: no expected entry queued");
            end else begin
                e = exp_q.pop_front();
                if (bus.read_data === e.exp) n_pass++;
                else $display("FAIL %s: read_data=%h expected=%h", e.name, bus.read_data, e.exp);
            end
        end
    end

    task automatic do_write(logic [9:0] a, logic [127:0] d);
        @(negedge clk);
        bus.read_write = 1'b1;
        bus.address    = a;
        bus.write_data = d;
        @(posedge clk);
        model_write(a, d);
        #1;
        bus.read_write = 1'b0;
    endtask

    task automatic read_at(string nm, logic [9:0] a);
        @(negedge clk);
        bus.read_write = 1'b0;
        bus.address    = a;
        #1;
        check(nm, a);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [127:0] d;
        logic [9:0]   a;
        logic         rw;
        bus.read_write = 1'b0;
        bus.address    = 10'h000;
        bus.write_data = '0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t1_reset_blk0", 10'h000);
        bus.address = 10'h3F0;
        #1;
        check("t2_reset_blk63", 10'h3F0);
        for (int b = 0; b < 64; b++) begin
            a = {b[5:0], 4'($urandom_range(0, 15))};
            bus.address = a;
            #1;
            check("reset_sweep", a);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Byte/word offset bits must be ignored on both write and read.
        do_write(10'h010, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA});
        read_at("t3_offset_ignored", 10'h01C);

        @(negedge clk);
        bus.read_write = 1'b0;
        bus.address    = 10'h020;
        bus.write_data = '1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_read_no_write", 10'h020);

        @(negedge clk);
        bus.read_write = 1'b1;
        bus.address    = 10'h040;
        bus.write_data = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        #1;
        check("t5_before_edge", 10'h040);
        @(posedge clk);
        model_write(10'h040, bus.write_data);
        #1;
        check("t5_after_edge", 10'h040);
        bus.read_write = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_reset", 10'h040);
        @(negedge clk);
        rst_n = 1'b1;

        do_write(10'h000, {32'h0A0A0003, 32'h0A0A0002, 32'h0A0A0001, 32'h0A0A0000});
        do_write(10'h3F0, {32'h3F3F0003, 32'h3F3F0002, 32'h3F3F0001, 32'h3F3F0000});
        read_at("t6_blk0", 10'h000);
        read_at("t6_blk63", 10'h3F0);
        read_at("t6_blk1", 10'h010);
        read_at("t6_blk62", 10'h3E0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a  = 10'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            rw = 1'($urandom_range(0, 1));
            bus.read_write = rw;
            bus.address    = a;
            bus.write_data = d;
            #1;
            check("rnd_pre_edge", a);
            @(posedge clk);
            if (rw) model_write(a, d);
            #1;
            check("rnd_post_edge", a);
            bus.read_write = 1'b0;
            if (i == 150) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rnd_mid_reset", a);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        for (int b = 0; b < 64; b++) read_at("final_sweep", {b[5:0], 4'h0});

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
